// File: rtl/reaction_pkg.sv
// Shared types, constants and BCD helpers for the reaction delay timer.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2,
        FOUL  = 2'd3
    } state_t;

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned PRE_W   = 20;

    // Taps 16,14,13,11 expressed as state bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Non-decimal nibbles 10..15 map onto 4..9.
    function automatic logic [3:0] bcd_fold(input logic [3:0] d);
        return (d > 4'd9) ? 4'(d - 4'd6) : d;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_fold4(input logic [BCD_W-1:0] v);
        return {bcd_fold(v[15:12]), bcd_fold(v[11:8]), bcd_fold(v[7:4]), bcd_fold(v[3:0])};
    endfunction

    // Subtract one with digit-wise borrow; caller guarantees v != 0.
    function automatic logic [BCD_W-1:0] bcd_dec4(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = 4'(v[4*i +: 4] - 4'd1);
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Random delay in 1000..2999 derived from the LFSR state.
    function automatic logic [BCD_W-1:0] lfsr_to_bcd(input logic [LFSR_W-1:0] s);
        return {4'(4'd1 + {3'b000, s[15]}), bcd_fold(s[11:8]), bcd_fold(s[7:4]), bcd_fold(s[3:0])};
    endfunction

endpackage

// File: rtl/reaction_delay_timer_if.sv
// Control and status bundle between the game controller and the delay timer.
interface reaction_delay_timer_if;
    import reaction_pkg::*;

    logic             start;
    logic             abort;
    logic             press;
    logic             load_en;
    logic [BCD_W-1:0] load_bcd;
    logic [BCD_W-1:0] remain_bcd;
    logic             go;
    logic             foul;
    logic             busy;

    modport master (
        output start, abort, press, load_en, load_bcd,
        input  remain_bcd, go, foul, busy
    );

    modport slave (
        input  start, abort, press, load_en, load_bcd,
        output remain_bcd, go, foul, busy
    );

endinterface

// File: rtl/delay_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed would lock up, so it is replaced.
module delay_lfsr16
    import reaction_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clock,
    input  logic              reset_button,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? DEFAULT_SEED : SEED;

    logic feedback;

    assign feedback = ^(state & LFSR_TAPS);

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button) begin
            state <= SEED_EFF;
        end else begin
            state <= {state[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/reaction_delay_timer.sv
// Randomised BCD countdown that raises go for the reaction game and flags false starts.
module reaction_delay_timer
    import reaction_pkg::*;
#(
    parameter int unsigned       TICK_DIV = 50000,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
    input  logic                   clock,
    input  logic                   reset_button,
    reaction_delay_timer_if.slave  bus
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state, state_n;
    logic [BCD_W-1:0] remain, remain_n;
    logic [PRE_W-1:0] pre, pre_n;
    logic             go_q, foul_q, busy_q;
    logic             go_n, foul_n, busy_n;
    logic [LFSR_W-1:0] lfsr;
    logic             tick;
    logic [BCD_W-1:0] remain_dec;

    delay_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clock        (clock),
        .reset_button (reset_button),
        .state        (lfsr)
    );

    assign tick       = (pre == PRE_LAST);
    assign remain_dec = bcd_dec4(remain);

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button) begin
            state  <= IDLE;
            remain <= '0;
            pre    <= '0;
            go_q   <= 1'b0;
            foul_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            remain <= remain_n;
            pre    <= pre_n;
            go_q   <= go_n;
            foul_q <= foul_n;
            busy_q <= busy_n;
        end
    end

    // Priority: abort > press (ARMED) > start > tick.
    always_comb begin
        state_n  = state;
        remain_n = remain;
        pre_n    = pre;

        if (bus.abort) begin
            state_n  = IDLE;
            remain_n = '0;
            pre_n    = '0;
        end else begin
            case (state)
                ARMED: begin
                    if (bus.press) begin
                        state_n = FOUL;
                    end else if (remain == '0) begin
                        state_n = FIRED;
                    end else begin
                        pre_n = tick ? '0 : PRE_W'(pre + PRE_W'(1));
                        if (tick) begin
                            remain_n = remain_dec;
                            if (remain_dec == '0) begin
                                state_n = FIRED;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_n  = ARMED;
                        pre_n    = '0;
                        remain_n = bus.load_en ? bcd_fold4(bus.load_bcd) : lfsr_to_bcd(lfsr);
                    end
                end
            endcase
        end

        go_n   = (state_n == FIRED);
        foul_n = (state_n == FOUL);
        busy_n = (state_n == ARMED);
    end

    assign bus.remain_bcd = remain;
    assign bus.go         = go_q;
    assign bus.foul       = foul_q;
    assign bus.busy       = busy_q;

endmodule
